// File: rtl/std_countones_acc_pkg.sv
// Shared width helper for the streaming popcount accumulator and its popcount sub-module.
package std_countones_acc_pkg;

  // Bits needed to hold a count of 0..w set bits.
  function automatic int calc_clogw(input int w);
    if (w > 1) return $clog2(w) + 1;
    return 1;
  endfunction

endpackage

// File: rtl/std_countones.sv
// Combinational population count of a W-bit word.
// Zero latency, no handshake; the caller registers the result.
module std_countones
  import std_countones_acc_pkg::*;
#(
  parameter int W    = 32,
  parameter int CNTW = calc_clogw(W)
) (
  input  logic [W-1:0]    data,
  output logic [CNTW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CNTW'(data[i]);
    end
  end

endmodule

// File: rtl/std_countones_acc.sv
// Per-frame ones/zeros tally over a valid/ready stream; STD_COUNTONES_ACC_SAT_EN selects saturating sums.
// Result valid one edge after the last word leaves S1; a stalled result only blocks a last word in S1.
module std_countones_acc
  import std_countones_acc_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [W-1:0]  i_data,
  input  logic          i_last,
  input  logic          i_mode,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [CW-1:0] o_count,
  output logic          o_ovf
);

  localparam int PW = calc_clogw(W);

  generate
    if (CW < PW) begin : g_cw_check
      $error("std_countones_acc: CW=%0d is narrower than the %0d bits a word count needs", CW, PW);
    end
  endgenerate

  logic [W-1:0]  word;
  logic [PW-1:0] word_cnt;
  logic          s1_valid;
  logic          s1_last;
  logic [CW-1:0] s1_cnt;
  logic [CW-1:0] acc;
  logic [CW-1:0] sum;
  logic          res_free;
  logic          s1_adv;
  logic          s1_close;

  // Zero counting is popcount of the inverted word.
  assign word = i_data ^ {W{i_mode}};

  std_countones #(.W(W)) u_popcount (
    .data  (word),
    .count (word_cnt)
  );

  assign res_free = !o_valid || i_ready;
  assign s1_adv   = s1_valid && (!s1_last || res_free);
  assign s1_close = s1_adv && s1_last;
  assign o_ready  = !s1_valid || s1_adv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_cnt   <= '0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_cnt  <= CW'(word_cnt);
        s1_last <= i_last;
      end
    end
  end

`ifdef STD_COUNTONES_ACC_SAT_EN
  logic [CW:0] sum_wide;
  logic        clamp;
  logic        ovf_acc;
  logic        frame_ovf;

  assign sum_wide  = {1'b0, acc} + {1'b0, s1_cnt};
  assign clamp     = sum_wide[CW];
  assign sum       = clamp ? {CW{1'b1}} : sum_wide[CW-1:0];
  assign frame_ovf = ovf_acc || clamp;

  // Overflow is sticky for the frame and travels out alongside its total.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_acc <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (s1_close) begin
      ovf_acc <= 1'b0;
      o_ovf   <= frame_ovf;
    end else if (s1_adv) begin
      ovf_acc <= frame_ovf;
    end
  end
`else
  assign sum   = acc + s1_cnt;
  assign o_ovf = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc     <= '0;
      o_valid <= 1'b0;
      o_count <= '0;
    end else if (s1_close) begin
      acc     <= '0;
      o_valid <= 1'b1;
      o_count <= sum;
    end else begin
      if (i_ready) o_valid <= 1'b0;
      if (s1_adv)  acc     <= sum;
    end
  end

endmodule

// File: tb/tb_std_countones_acc.sv
// Bench for std_countones_acc: directed W=8/CW=4 scenarios plus randomized W=13/CW=10 frames.
module tb_std_countones_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_valid, a_ready, a_last, a_mode, a_ovalid, a_iready, a_ovf;
  logic [7:0] a_data;
  logic [3:0] a_count;

  logic        b_valid, b_ready, b_last, b_mode, b_ovalid, b_iready, b_ovf;
  logic [12:0] b_data;
  logic [9:0]  b_count;

  int errors = 0;
  int checks = 0;

  logic [4:0]  qa[$];
  logic [10:0] qb[$];

  std_countones_acc #(.W(8), .CW(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready),
    .i_data(a_data), .i_last(a_last), .i_mode(a_mode), .o_valid(a_ovalid),
    .i_ready(a_iready), .o_count(a_count), .o_ovf(a_ovf)
  );

  std_countones_acc #(.W(13), .CW(10)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready),
    .i_data(b_data), .i_last(b_last), .i_mode(b_mode), .o_valid(b_ovalid),
    .i_ready(b_iready), .o_count(b_count), .o_ovf(b_ovf)
  );

  // Drive one word and hold it until accepted; returns at the accepting edge.
  task automatic send_a(input logic [7:0] d, input logic l, input logic m);
    int n = 0;
    @(negedge clk);
    a_valid = 1'b1; a_data = d; a_last = l; a_mode = m;
    #1;
    while (!a_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (!a_ready) begin
      errors++;
      $display("FAIL send_a_accept: word %h not accepted within %0d cycles", d, n);
    end
    @(posedge clk);
  endtask

  task automatic send_b(input logic [12:0] d, input logic l, input logic m);
    int n = 0;
    @(negedge clk);
    b_valid = 1'b1; b_data = d; b_last = l; b_mode = m;
    #1;
    while (!b_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (!b_ready) begin
      errors++;
      $display("FAIL send_b_accept: word %h not accepted within %0d cycles", d, n);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_ovalid, a_count, a_ovf} !== 6'b0) begin
      errors++;
      $display("FAIL reset_a_outputs: got valid=%b cnt=%0d ovf=%b, want all 0", a_ovalid, a_count, a_ovf);
    end
    checks++;
    if ({b_ovalid, b_count, b_ovf} !== 12'b0) begin
      errors++;
      $display("FAIL reset_b_outputs: got valid=%b cnt=%0d ovf=%b, want all 0", b_ovalid, b_count, b_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got a=%b b=%b, want 1 1", a_ready, b_ready);
    end
  endtask

  task automatic test_basic();
    logic [4:0] exp;
    a_iready = 1'b1;
    qa.push_back({1'b0, 4'd13});
    send_a(8'hFF, 1'b0, 1'b0);
    send_a(8'h0F, 1'b0, 1'b0);
    send_a(8'h01, 1'b1, 1'b0);
    @(negedge clk); a_valid = 1'b0; #1;
    checks++;
    if (a_ovalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: o_valid=%b one edge after last, want 0", a_ovalid);
    end
    @(negedge clk); #1;
    exp = qa.pop_front();
    checks++;
    if (a_ovalid !== 1'b1 || {a_ovf, a_count} !== exp) begin
      errors++;
      $display("FAIL basic_count: got valid=%b cnt=%0d ovf=%b, want valid=1 cnt=%0d ovf=%b",
               a_ovalid, a_count, a_ovf, exp[3:0], exp[4]);
    end
    @(negedge clk); #1;
    checks++;
    if (a_ovalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_consumed: o_valid=%b after consume, want 0", a_ovalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    a_iready = 1'b1;
    qa.push_back({1'b0, 4'd6});
    qa.push_back({1'b0, 4'd0});
    send_a(8'h03, 1'b1, 1'b1);
    send_a(8'h00, 1'b1, 1'b0);
    @(negedge clk); a_valid = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      exp = qa.pop_front();
      checks++;
      if (a_ovalid !== 1'b1 || {a_ovf, a_count} !== exp) begin
        errors++;
        $display("FAIL b2b_result%0d: got valid=%b cnt=%0d ovf=%b, want valid=1 cnt=%0d ovf=%b",
                 k, a_ovalid, a_count, a_ovf, exp[3:0], exp[4]);
      end
      @(negedge clk); #1;
    end
    checks++;
    if (a_ovalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: o_valid=%b, want 0", a_ovalid);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp;
    a_iready = 1'b0;
    qa.push_back({1'b0, 4'd8});
    qa.push_back({1'b0, 4'd1});
    send_a(8'hFF, 1'b1, 1'b0);
    send_a(8'h80, 1'b1, 1'b0);
    @(negedge clk); a_valid = 1'b0;
    repeat (5) begin
      #1;
      checks++;
      if (a_ovalid !== 1'b1 || {a_ovf, a_count} !== qa[0] || a_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b cnt=%0d ovf=%b rdy=%b, want valid=1 cnt=%0d ovf=%b rdy=0",
                 a_ovalid, a_count, a_ovf, a_ready, qa[0][3:0], qa[0][4]);
      end
      @(negedge clk);
    end
    a_iready = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp = qa.pop_front();
      checks++;
      if (a_ovalid !== 1'b1 || {a_ovf, a_count} !== exp) begin
        errors++;
        $display("FAIL bp_release%0d: got valid=%b cnt=%0d ovf=%b, want valid=1 cnt=%0d ovf=%b",
                 k, a_ovalid, a_count, a_ovf, exp[3:0], exp[4]);
      end
      @(negedge clk); #1;
    end
    checks++;
    if (a_ovalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: o_valid=%b, want 0", a_ovalid);
    end
  endtask

  task automatic test_saturation();
    logic [4:0] exp;
    a_iready = 1'b1;
`ifdef STD_COUNTONES_ACC_SAT_EN
    qa.push_back({1'b1, 4'd15});
`else
    qa.push_back({1'b0, 4'd8});
`endif
    send_a(8'hFF, 1'b0, 1'b0);
    send_a(8'hFF, 1'b0, 1'b0);
    send_a(8'hFF, 1'b1, 1'b0);
    @(negedge clk); a_valid = 1'b0;
    @(negedge clk); #1;
    exp = qa.pop_front();
    checks++;
    if (a_ovalid !== 1'b1 || {a_ovf, a_count} !== exp) begin
      errors++;
      $display("FAIL sat_result: got valid=%b cnt=%0d ovf=%b, want valid=1 cnt=%0d ovf=%b",
               a_ovalid, a_count, a_ovf, exp[3:0], exp[4]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [4:0] exp;
    a_iready = 1'b0;
    send_a(8'h01, 1'b1, 1'b0);
    send_a(8'hFF, 1'b0, 1'b0);
    send_a(8'hFF, 1'b0, 1'b0);
    @(negedge clk); a_valid = 1'b0; rst_n = 1'b0; #1;
    checks++;
    if (a_ovalid !== 1'b0 || a_count !== 4'd0 || a_ovf !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%b cnt=%0d ovf=%b, want 0 0 0", a_ovalid, a_count, a_ovf);
    end
    @(negedge clk); rst_n = 1'b1; a_iready = 1'b1;
    qa.push_back({1'b0, 4'd1});
    send_a(8'h01, 1'b1, 1'b0);
    @(negedge clk); a_valid = 1'b0;
    @(negedge clk); #1;
    exp = qa.pop_front();
    checks++;
    if (a_ovalid !== 1'b1 || {a_ovf, a_count} !== exp) begin
      errors++;
      $display("FAIL midreset_result: got valid=%b cnt=%0d ovf=%b, want valid=1 cnt=%0d ovf=%b",
               a_ovalid, a_count, a_ovf, exp[3:0], exp[4]);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int got = 0;
    int cyc = 0;
    fork
      begin
        for (int f = 0; f < 1000; f++) begin
          int nw, acc, c;
          logic ovf;
          logic [12:0] d;
          logic m;
          nw  = $urandom_range(1, 20);
          acc = 0;
          ovf = 1'b0;
          for (int w = 0; w < nw; w++) begin
            while ($urandom_range(0, 3) == 0) begin
              @(negedge clk); b_valid = 1'b0;
            end
            d = 13'($urandom);
            m = 1'($urandom_range(0, 1));
            c = $countones(d ^ (m ? 13'h1FFF : 13'h0000));
`ifdef STD_COUNTONES_ACC_SAT_EN
            if (acc + c > 1023) begin
              acc = 1023; ovf = 1'b1;
            end else acc = acc + c;
`else
            acc = (acc + c) % 1024;
`endif
            if (w == nw - 1) qb.push_back({ovf, 10'(acc)});
            send_b(d, (w == nw - 1), m);
          end
        end
        @(negedge clk); b_valid = 1'b0;
      end
      begin
        while (got < 1000 && cyc < 60000) begin
          logic [10:0] exp;
          @(negedge clk);
          b_iready = ($urandom_range(0, 3) != 0);
          #1;
          if (b_ovalid && b_iready) begin
            checks++;
            if (qb.size() == 0) begin
              errors++;
              $display("FAIL rand_result%0d: got cnt=%0d with no frame expected", got, b_count);
            end else begin
              exp = qb.pop_front();
              if ({b_ovf, b_count} !== exp) begin
                errors++;
                $display("FAIL rand_result%0d: got cnt=%0d ovf=%b, want cnt=%0d ovf=%b",
                         got, b_count, b_ovf, exp[9:0], exp[10]);
              end
            end
            got++;
          end
          cyc++;
        end
        checks++;
        if (got < 1000) begin
          errors++;
          $display("FAIL rand_timeout: got %0d results, want 1000", got);
        end
      end
    join
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0; a_mode = 1'b0; a_iready = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_mode = 1'b0; b_iready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
